mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port DRAM scheduler between the cache and the external DRAM controller.
- Serves three requesters: program line fill, data line fill, and write-back FIFO drain.
- Line fills read one 512-bit line as BEATS read beats, assemble it, and deliver it to the cache with a one-cycle line-write strobe.
- Write-backs issue single 32-bit word writes and pop the cache write-back FIFO.

Parameters:
- BEATS, 4, read beats per 512-bit line; beat width is 512/BEATS.
- LINE_ADDR_W, 21, line address width from the cache (64-byte lines).
- DRAM_ADDR_W, 27, DRAM byte address width; equals LINE_ADDR_W+6.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- is_req_f_prog  in  1  cache requests a program line fill; held until the line is written
- req_addr_f_prog  in  LINE_ADDR_W  program fill line address
- is_req_f_data  in  1  cache requests a data line fill; held until the line is written
- req_addr_f_data  in  LINE_ADDR_W  data fill line address
- fifo_empty  in  1  write-back FIFO is empty
- write_back_addr  in  32  head entry byte address
- write_back_data  in  32  head entry data
- dram_req_ready  in  1  DRAM accepts the current request
- dram_rvalid  in  1  read beat valid
- dram_rdata  in  512/BEATS  read beat data
- dram_req_valid  out  1  DRAM request valid
- dram_req_we  out  1  1 = write, 0 = line read
- dram_req_addr  out  DRAM_ADDR_W  byte address
- dram_wdata  out  32  write data
- is_write_t_main  out  1  one-cycle pulse: FIFO head consumed (pop)
- is_write_prog_line  out  1  one-cycle pulse: read_prog_data/addr valid
- is_write_data_line  out  1  one-cycle pulse: read_data_data/addr valid
- read_prog_data  out  512  assembled program line
- read_prog_addr  out  7  cache index = fill address[6:0]
- read_data_data  out  512  assembled data line
- read_data_addr  out  7  cache index = fill address[6:0]
- busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: every output is 0; state = IDLE; beat counter = 0; line buffer = 0.
- Reset mid-operation: the outstanding request is abandoned. dram_req_valid drops the cycle after reset is sampled, and late beats are ignored because rvalid is only observed in RD_DATA.
- Priority, evaluated in IDLE:
  - prog fill first.
  - Then write-back drain, while !fifo_empty.
  - Then data fill.
  - Data fills are never served while the FIFO is non-empty (read-after-write ordering). Program fills bypass the FIFO.
- On grant, latch the class and address. Request sampled in IDLE at cycle N gives dram_req_valid at N+1.
- States:
  - IDLE: select a requester as above; stay in IDLE if none.
  - RD_REQ: dram_req_valid=1, we=0, addr={line_addr,6'b0}. Hold all outputs stable until dram_req_ready; then go to RD_DATA with cnt=0.
  - RD_DATA: on each dram_rvalid, write the beat into line bits [cnt*BW +: BW] (beat 0 is the LSB) and increment cnt. When the beat with cnt==BEATS-1 arrives, go to LINE_WR. Cycles without rvalid hold.
  - LINE_WR: one cycle. Drive the selected read_*_data/addr and pulse the matching is_write_*_line. Go to GAP.
  - WB_REQ: dram_req_valid=1, we=1, addr=write_back_addr[26:0], wdata=write_back_data. On dram_req_ready, pulse is_write_t_main in the next cycle (WB_POP), then go to GAP.
  - GAP: one idle cycle so the cache can drop is_req_f_* or update fifo_empty and the FIFO head. Then go to IDLE.
- read_*_data/addr hold their last values between strobes. Only one line strobe or pop pulse is high in any cycle.
- Requests that arrive or change while the block is busy are ignored until IDLE. The latched address is used throughout a transaction.
- dram_req_valid never drops before ready (valid/ready rule).

Decomposition:
- Package kasumi_mem_pkg holds:
  - state enum {IDLE, RD_REQ, RD_DATA, LINE_WR, WB_REQ, WB_POP, GAP}
  - grant enum {G_PROG, G_DATA}
  - constants LINE_W=512, LINE_ADDR_W, DRAM_ADDR_W
- Sub-module line_assembler: beat counter plus 512-bit line buffer, with clear/beat_valid inputs and a last_beat output.

Test Plan:
- prog request addr 21'h00045, ready after 2 cycles, 4 beats 0x…A0..A3 -> dram_req_addr=27'h0001140, we=0. One is_write_prog_line pulse with read_prog_addr=7'h45 and beat0 in bits[127:0].
- prog and data requested together, FIFO empty -> prog served first, then data. Two separate strobes at least 2 cycles apart.
- data request with 2 FIFO entries (0x100→0xDEAD, 0x104→0xBEEF) -> two writes issued in order, each followed by a 1-cycle is_write_t_main pulse. Data read is issued only after fifo_empty=1.
- dram_req_ready held low 10 cycles -> valid, addr and we stay stable. rvalid with gaps between beats -> still 4 beats collected and one strobe.
- reset during RD_DATA after 2 beats -> next cycle state is IDLE and outputs are 0. Stray rvalid afterwards causes no strobe. A fresh request afterwards completes normally.
- stray dram_rvalid while IDLE or in WB_REQ -> ignored, no strobe.

Source files
------------

// File: rtl/kasumi_mem_pkg.sv
// Shared types and sizes for the cache-side DRAM scheduler.
// Line geometry, FSM states and requester classes.
package kasumi_mem_pkg;

  localparam int LINE_W      = 512;
  localparam int LINE_ADDR_W = 21;
  localparam int DRAM_ADDR_W = LINE_ADDR_W + 6;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    LINE_WR,
    WB_REQ,
    WB_POP,
    GAP
  } state_t;

  typedef enum logic {
    G_PROG,
    G_DATA
  } grant_t;

endpackage

// File: rtl/line_assembler.sv
// Collects DRAM read beats into one cache line.
// Beat 0 lands in the least significant bits.
module line_assembler
  import kasumi_mem_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    beat_valid,
  input  logic [LINE_W/BEATS-1:0] beat_data,
  output logic [LINE_W-1:0]       line,
  output logic                    last_beat
);

  localparam int BW = LINE_W / BEATS;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0] cnt;

  assign last_beat = (cnt == CW'(BEATS - 1));

  // beat counter and line buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      line <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (beat_valid) begin
      line[cnt*BW +: BW] <= beat_data;
      cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port DRAM scheduler: program fill, write-back
// drain and data fill, one transaction at a time.
module mem_arbiter
  import kasumi_mem_pkg::*;
#(
  parameter int BEATS       = 4,
  parameter int LINE_ADDR_W = kasumi_mem_pkg::LINE_ADDR_W,
  parameter int DRAM_ADDR_W = kasumi_mem_pkg::DRAM_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_req_f_prog,
  input  logic [LINE_ADDR_W-1:0]  req_addr_f_prog,
  input  logic                    is_req_f_data,
  input  logic [LINE_ADDR_W-1:0]  req_addr_f_data,
  input  logic                    fifo_empty,
  input  logic [31:0]             write_back_addr,
  input  logic [31:0]             write_back_data,
  input  logic                    dram_req_ready,
  input  logic                    dram_rvalid,
  input  logic [LINE_W/BEATS-1:0] dram_rdata,
  output logic                    dram_req_valid,
  output logic                    dram_req_we,
  output logic [DRAM_ADDR_W-1:0]  dram_req_addr,
  output logic [31:0]             dram_wdata,
  output logic                    is_write_t_main,
  output logic                    is_write_prog_line,
  output logic                    is_write_data_line,
  output logic [LINE_W-1:0]       read_prog_data,
  output logic [6:0]              read_prog_addr,
  output logic [LINE_W-1:0]       read_data_data,
  output logic [6:0]              read_data_addr,
  output logic                    busy
);

  state_t                 state;
  state_t                 state_next;
  grant_t                 grant;
  logic [LINE_ADDR_W-1:0] line_addr;
  logic [DRAM_ADDR_W-1:0] wb_addr;
  logic [31:0]            wb_data;
  logic [LINE_W-1:0]      line;
  logic [LINE_W-1:0]      prog_hold;
  logic [LINE_W-1:0]      data_hold;
  logic [6:0]             prog_idx;
  logic [6:0]             data_idx;
  logic                   last_beat;
  logic                   beat_valid;
  logic                   clear;
  logic                   unused_wb_hi;

  assign unused_wb_hi = ^write_back_addr[31:DRAM_ADDR_W];

  // beats only count while waiting for read data
  assign beat_valid = (state == RD_DATA) && dram_rvalid;
  assign clear      = (state == RD_REQ) && dram_req_ready;

  line_assembler #(
    .BEATS(BEATS)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .beat_valid(beat_valid),
    .beat_data (dram_rdata),
    .line      (line),
    .last_beat (last_beat)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state: fixed priority prog > write-back > data
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (is_req_f_prog)      state_next = RD_REQ;
        else if (!fifo_empty)   state_next = WB_REQ;
        else if (is_req_f_data) state_next = RD_REQ;
      end
      RD_REQ:  if (dram_req_ready) state_next = RD_DATA;
      RD_DATA: if (dram_rvalid && last_beat) state_next = LINE_WR;
      LINE_WR: state_next = GAP;
      WB_REQ:  if (dram_req_ready) state_next = WB_POP;
      WB_POP:  state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // latch class and address at grant time
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= G_PROG;
      line_addr <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else if (state == IDLE) begin
      if (is_req_f_prog) begin
        grant     <= G_PROG;
        line_addr <= req_addr_f_prog;
      end else if (!fifo_empty) begin
        wb_addr <= write_back_addr[DRAM_ADDR_W-1:0];
        wb_data <= write_back_data;
      end else if (is_req_f_data) begin
        grant     <= G_DATA;
        line_addr <= req_addr_f_data;
      end
    end
  end

  // keep the last delivered line visible between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_hold <= '0;
      prog_idx  <= '0;
      data_hold <= '0;
      data_idx  <= '0;
    end else if (state == LINE_WR) begin
      if (grant == G_PROG) begin
        prog_hold <= line;
        prog_idx  <= line_addr[6:0];
      end else begin
        data_hold <= line;
        data_idx  <= line_addr[6:0];
      end
    end
  end

  // outputs decoded from state and latched request
  always_comb begin
    dram_req_valid     = 1'b0;
    dram_req_we        = 1'b0;
    dram_req_addr      = '0;
    dram_wdata         = '0;
    is_write_t_main    = 1'b0;
    is_write_prog_line = 1'b0;
    is_write_data_line = 1'b0;
    read_prog_data     = prog_hold;
    read_prog_addr     = prog_idx;
    read_data_data     = data_hold;
    read_data_addr     = data_idx;
    busy               = (state != IDLE);
    unique case (state)
      RD_REQ: begin
        dram_req_valid = 1'b1;
        dram_req_addr  = {line_addr, 6'b0};
      end
      WB_REQ: begin
        dram_req_valid = 1'b1;
        dram_req_we    = 1'b1;
        dram_req_addr  = wb_addr;
        dram_wdata     = wb_data;
      end
      LINE_WR: begin
        if (grant == G_PROG) begin
          is_write_prog_line = 1'b1;
          read_prog_data     = line;
          read_prog_addr     = line_addr[6:0];
        end else begin
          is_write_data_line = 1'b1;
          read_data_data     = line;
          read_data_addr     = line_addr[6:0];
        end
      end
      WB_POP:  is_write_t_main = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cache and DRAM
// models drive random traffic against a transaction-order model.
module tb_mem_arbiter;

  localparam int BEATS = 4;
  localparam int BW    = 512 / BEATS;

  typedef struct packed {
    logic        we;
    logic [26:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_t;

  logic          clk;
  logic          reset;
  logic          is_req_f_prog;
  logic [20:0]   req_addr_f_prog;
  logic          is_req_f_data;
  logic [20:0]   req_addr_f_data;
  logic          fifo_empty;
  logic [31:0]   write_back_addr;
  logic [31:0]   write_back_data;
  logic          dram_req_ready;
  logic          dram_rvalid;
  logic [BW-1:0] dram_rdata;
  logic          dram_req_valid;
  logic          dram_req_we;
  logic [26:0]   dram_req_addr;
  logic [31:0]   dram_wdata;
  logic          is_write_t_main;
  logic          is_write_prog_line;
  logic          is_write_data_line;
  logic [511:0]  read_prog_data;
  logic [6:0]    read_prog_addr;
  logic [511:0]  read_data_data;
  logic [6:0]    read_data_addr;
  logic          busy;

  mem_arbiter #(.BEATS(BEATS)) dut (
    .clk               (clk),
    .reset             (reset),
    .is_req_f_prog     (is_req_f_prog),
    .req_addr_f_prog   (req_addr_f_prog),
    .is_req_f_data     (is_req_f_data),
    .req_addr_f_data   (req_addr_f_data),
    .fifo_empty        (fifo_empty),
    .write_back_addr   (write_back_addr),
    .write_back_data   (write_back_data),
    .dram_req_ready    (dram_req_ready),
    .dram_rvalid       (dram_rvalid),
    .dram_rdata        (dram_rdata),
    .dram_req_valid    (dram_req_valid),
    .dram_req_we       (dram_req_we),
    .dram_req_addr     (dram_req_addr),
    .dram_wdata        (dram_wdata),
    .is_write_t_main   (is_write_t_main),
    .is_write_prog_line(is_write_prog_line),
    .is_write_data_line(is_write_data_line),
    .read_prog_data    (read_prog_data),
    .read_prog_addr    (read_prog_addr),
    .read_data_data    (read_data_data),
    .read_data_addr    (read_data_addr),
    .busy              (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  req_t         log_q[$];
  wb_t          wbq[$];
  logic [BW-1:0] beat_q[$];
  logic [511:0] gen_lines[$];
  logic [511:0] prog_lines[$];
  logic [511:0] data_lines[$];
  logic [6:0]   prog_addrs[$];
  logic [6:0]   data_addrs[$];

  int  cyc = 0;
  int  prog_cyc = 0;
  int  data_cyc = 0;
  int  pop_cnt = 0;
  int  beats_sent = 0;
  int  wait_cnt = 0;
  int  lat_fixed = -1;
  int  gap_pct = 0;
  bit  resp_en = 0;
  bit  stray_en = 0;
  bit  fixed_beats = 0;
  bit  pend_read = 0;

  logic         prev_valid = 0;
  logic         prev_ready = 0;
  logic         prev_we = 0;
  logic [26:0]  prev_addr = '0;
  logic [31:0]  prev_wdata = '0;

  logic [511:0] exp_prog_hold = '0;
  logic [511:0] exp_data_hold = '0;
  logic [6:0]   exp_prog_idx = '0;
  logic [6:0]   exp_data_idx = '0;

  task automatic check(input string tag,
                       input logic [511:0] obs,
                       input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_lat();
    if (lat_fixed >= 0) return lat_fixed;
    return int'($urandom_range(3));
  endfunction

  // one clock: observe DUT, then act as cache and DRAM for the next edge
  task automatic step();
    @(negedge clk);
    cyc++;
    check("pulse_onehot",
          $countones({is_write_prog_line, is_write_data_line,
                      is_write_t_main}) <= 1, 1);
    if (prev_valid && !prev_ready)
      check("valid_hold",
            {dram_req_valid, dram_req_we, dram_req_addr, dram_wdata},
            {1'b1, prev_we, prev_addr, prev_wdata});
    if (is_write_prog_line) begin
      prog_lines.push_back(read_prog_data);
      prog_addrs.push_back(read_prog_addr);
      prog_cyc = cyc;
      is_req_f_prog = 1'b0;
    end
    if (is_write_data_line) begin
      data_lines.push_back(read_data_data);
      data_addrs.push_back(read_data_addr);
      data_cyc = cyc;
      is_req_f_data = 1'b0;
    end
    if (is_write_t_main) begin
      pop_cnt++;
      if (wbq.size() > 0) void'(wbq.pop_front());
    end
    fifo_empty      = (wbq.size() == 0);
    write_back_addr = (wbq.size() > 0) ? wbq[0].addr : 32'h0;
    write_back_data = (wbq.size() > 0) ? wbq[0].data : 32'h0;

    if (pend_read) begin
      logic [511:0] ln;
      ln = '0;
      for (int i = 0; i < BEATS; i++) begin
        logic [BW-1:0] b;
        if (fixed_beats) b = {16{8'(8'hA0 + i)}};
        else b = {$urandom, $urandom, $urandom, $urandom};
        beat_q.push_back(b);
        ln[i*BW +: BW] = b;
      end
      gen_lines.push_back(ln);
      pend_read = 0;
    end

    dram_req_ready = 1'b0;
    if (resp_en && !reset && dram_req_valid) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        dram_req_ready = 1'b1;
        log_q.push_back('{we: dram_req_we, addr: dram_req_addr,
                          wdata: dram_wdata});
        if (!dram_req_we) pend_read = 1;
        wait_cnt = next_lat();
      end
    end

    dram_rvalid = 1'b0;
    dram_rdata  = '0;
    if (resp_en && beat_q.size() > 0 &&
        int'($urandom_range(99)) >= gap_pct) begin
      dram_rvalid = 1'b1;
      dram_rdata  = beat_q.pop_front();
      beats_sent++;
    end else if (stray_en) begin
      dram_rvalid = 1'b1;
      dram_rdata  = {$urandom, $urandom, $urandom, $urandom};
    end

    prev_valid = dram_req_valid && !reset;
    prev_ready = dram_req_ready;
    prev_we    = dram_req_we;
    prev_addr  = dram_req_addr;
    prev_wdata = dram_wdata;
  endtask

  function automatic bit all_done();
    return !is_req_f_prog && !is_req_f_data && wbq.size() == 0 &&
           !busy && beat_q.size() == 0 && !pend_read;
  endfunction

  // apply a set of simultaneous requests and check the served order
  task automatic batch(input bit p, input bit d,
                       input logic [20:0] pa, input logic [20:0] da,
                       input string tg);
    req_t exp_q[$];
    int   n_w;
    int   lim;
    int   di;
    log_q.delete();
    gen_lines.delete();
    prog_lines.delete();
    data_lines.delete();
    prog_addrs.delete();
    data_addrs.delete();
    pop_cnt = 0;
    n_w = wbq.size();
    if (p) exp_q.push_back('{we: 1'b0, addr: {pa, 6'b0}, wdata: 32'h0});
    foreach (wbq[i])
      exp_q.push_back('{we: 1'b1, addr: wbq[i].addr[26:0],
                        wdata: wbq[i].data});
    if (d) exp_q.push_back('{we: 1'b0, addr: {da, 6'b0}, wdata: 32'h0});
    is_req_f_prog   = p;
    req_addr_f_prog = pa;
    is_req_f_data   = d;
    req_addr_f_data = da;
    fifo_empty      = (wbq.size() == 0);
    write_back_addr = (wbq.size() > 0) ? wbq[0].addr : 32'h0;
    write_back_data = (wbq.size() > 0) ? wbq[0].data : 32'h0;
    wait_cnt = next_lat();
    lim = 0;
    do begin
      step();
      lim++;
    end while (!all_done() && lim < 400);
    check({tg, "_done"}, lim < 400, 1);
    check({tg, "_nreq"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tg, "_we"}, log_q[i].we, exp_q[i].we);
      check({tg, "_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we)
        check({tg, "_wdata"}, log_q[i].wdata, exp_q[i].wdata);
    end
    check({tg, "_nprog"}, prog_lines.size(), p);
    check({tg, "_ndata"}, data_lines.size(), d);
    check({tg, "_pops"}, pop_cnt, n_w);
    if (p && gen_lines.size() > 0) begin
      exp_prog_hold = gen_lines[0];
      exp_prog_idx  = pa[6:0];
    end
    di = p ? 1 : 0;
    if (d && gen_lines.size() > di) begin
      exp_data_hold = gen_lines[di];
      exp_data_idx  = da[6:0];
    end
    if (p && prog_lines.size() > 0) begin
      check({tg, "_pline"}, prog_lines[0], exp_prog_hold);
      check({tg, "_pidx"}, prog_addrs[0], exp_prog_idx);
    end
    if (d && data_lines.size() > 0) begin
      check({tg, "_dline"}, data_lines[0], exp_data_hold);
      check({tg, "_didx"}, data_addrs[0], exp_data_idx);
    end
    check({tg, "_phold"}, {read_prog_addr, read_prog_data},
          {exp_prog_idx, exp_prog_hold});
    check({tg, "_dhold"}, {read_data_addr, read_data_data},
          {exp_data_idx, exp_data_hold});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] b0;
    int lim;
    reset           = 1'b1;
    is_req_f_prog   = 1'b0;
    req_addr_f_prog = '0;
    is_req_f_data   = 1'b0;
    req_addr_f_data = '0;
    fifo_empty      = 1'b1;
    write_back_addr = '0;
    write_back_data = '0;
    dram_req_ready  = 1'b0;
    dram_rvalid     = 1'b0;
    dram_rdata      = '0;
    repeat (3) step();
    check("reset_ctl",
          {dram_req_valid, dram_req_we, dram_req_addr, dram_wdata,
           is_write_t_main, is_write_prog_line, is_write_data_line,
           read_prog_addr, read_data_addr, busy}, 0);
    check("reset_lines", read_prog_data | read_data_data, 0);
    reset   = 1'b0;
    resp_en = 1;

    fixed_beats = 1;
    lat_fixed   = 2;
    batch(1, 0, 21'h00045, 21'h0, "t1");
    if (log_q.size() > 0) check("t1_addr", log_q[0].addr, 27'h0001140);
    if (prog_lines.size() > 0) begin
      b0 = {16{8'hA0}};
      check("t1_beat0", prog_lines[0][127:0], b0);
      check("t1_idx", prog_addrs[0], 7'h45);
    end
    fixed_beats = 0;
    lat_fixed   = -1;
    gap_pct     = 25;

    batch(1, 1, 21'($urandom), 21'($urandom), "t2");
    check("t2_gap", (data_cyc - prog_cyc) >= 2, 1);

    wbq.push_back('{addr: 32'h100, data: 32'hDEAD});
    wbq.push_back('{addr: 32'h104, data: 32'hBEEF});
    batch(0, 1, 21'h0, 21'($urandom), "t3");

    lat_fixed = 10;
    gap_pct   = 50;
    batch(0, 1, 21'h0, 21'($urandom), "t4d");
    batch(1, 0, 21'($urandom), 21'h0, "t4p");
    lat_fixed = 1;
    gap_pct   = 0;

    beats_sent      = 0;
    prog_lines.delete();
    data_lines.delete();
    is_req_f_prog   = 1'b1;
    req_addr_f_prog = 21'($urandom);
    wait_cnt        = 1;
    lim = 0;
    while (beats_sent < 2 && lim < 100) begin
      step();
      lim++;
    end
    check("t5_reach", beats_sent >= 2, 1);
    resp_en = 0;
    step();
    reset         = 1'b1;
    is_req_f_prog = 1'b0;
    beat_q.delete();
    pend_read = 0;
    step();
    check("t5_busy", busy, 0);
    check("t5_ctl",
          {dram_req_valid, dram_req_we, dram_req_addr, dram_wdata,
           is_write_t_main, is_write_prog_line, is_write_data_line,
           read_prog_addr, read_data_addr}, 0);
    check("t5_lines", read_prog_data | read_data_data, 0);
    exp_prog_hold = '0;
    exp_data_hold = '0;
    exp_prog_idx  = '0;
    exp_data_idx  = '0;
    reset    = 1'b0;
    stray_en = 1;
    repeat (5) step();
    stray_en = 0;
    check("t5_nostrobe", prog_lines.size() + data_lines.size(), 0);
    resp_en   = 1;
    lat_fixed = -1;
    gap_pct   = 25;
    batch(1, 0, 21'($urandom), 21'h0, "t5b");

    stray_en = 1;
    repeat (4) step();
    check("t6_idle", prog_lines.size() + data_lines.size(), 1);
    lat_fixed = 4;
    wbq.push_back('{addr: $urandom & 32'hFFFF_FFFC, data: $urandom});
    batch(0, 0, 21'h0, 21'h0, "t6");
    stray_en  = 0;
    lat_fixed = -1;

    repeat (25) begin
      bit p;
      bit d;
      int nw;
      p  = 1'($urandom_range(1));
      d  = 1'($urandom_range(1));
      nw = int'($urandom_range(3));
      if (!p && !d && nw == 0) p = 1;
      for (int k = 0; k < nw; k++)
        wbq.push_back('{addr: $urandom & 32'hFFFF_FFFC, data: $urandom});
      batch(p, d, 21'($urandom), 21'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
